// File: rtl/router_pkg.sv
// Shared constants, hold-queue entry type and the running check-byte update used by the
// packet datapath register.
package router_pkg;

  localparam int PARITY_XOR = 0;
  localparam int PARITY_CRC = 1;
  localparam int CHK_MAX_W  = 32;

  typedef struct packed {
    logic                 last;
    logic [CHK_MAX_W-1:0] data;
  } hold_entry_t;

  // XOR: acc ^ d.  CRC: acc ^ d shifted MSB-first through poly for `width` bits.
  function automatic logic [CHK_MAX_W-1:0] chk_update(
    input int                   mode,
    input int                   width,
    input logic [CHK_MAX_W-1:0] poly,
    input logic [CHK_MAX_W-1:0] acc,
    input logic [CHK_MAX_W-1:0] d
  );
    logic [CHK_MAX_W-1:0] mask;
    logic [CHK_MAX_W-1:0] msb;
    logic [CHK_MAX_W-1:0] c;
    mask = (width >= CHK_MAX_W) ? '1 : ((CHK_MAX_W'(1) << width) - CHK_MAX_W'(1));
    msb  = CHK_MAX_W'(1) << (width - 1);
    c    = (acc ^ d) & mask;
    if (mode == PARITY_CRC) begin
      for (int i = 0; i < CHK_MAX_W; i++) begin
        if (i < width) begin
          if ((c & msb) != '0) c = ((c << 1) ^ poly) & mask;
          else                 c = (c << 1) & mask;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/router_pkt_reg_p_if.sv
// Control strobes, byte input and registered outputs of the packet datapath register.
interface router_pkt_reg_p_if #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 2
);
  localparam int CW = $clog2(HOLD_DEPTH + 1);

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              err;
  logic              len_err;
  logic              hold_ovf;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [CW-1:0]     hold_count;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state, laf_state, rst_int_reg,
    input  dout, dout_valid, err, len_err, hold_ovf, parity_done, low_pkt_valid, hold_count
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state, laf_state, rst_int_reg,
    output dout, dout_valid, err, len_err, hold_ovf, parity_done, low_pkt_valid, hold_count
  );
endinterface

// File: rtl/router_hold_fifo.sv
// Small synchronous FIFO holding bytes while the output FIFO is full; push and pop may
// coincide, and a push into a full queue is ignored unless a pop frees a slot.
module router_hold_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/router_pkt_reg_p.sv
// Packet datapath register: captures the header, forwards payload and check byte to the
// output FIFO (via a hold queue while it is full) and checks check byte and length.
module router_pkt_reg_p
  import router_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 2,
  parameter int                HOLD_DEPTH  = 2,
  parameter int                PARITY_MODE = PARITY_XOR,
  parameter logic [DATA_W-1:0] CRC_POLY    = 'h07
) (
  input logic                clock,
  input logic                resetn,
  router_pkt_reg_p_if.slave  bus
);
  localparam int CW = $clog2(HOLD_DEPTH + 1);

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] chk_acc_q, chk_acc_d;
  logic [DATA_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              err_q, err_d;
  logic              len_err_q, len_err_d;
  logic              hold_ovf_q, hold_ovf_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;

  logic              fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_wdata, fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] chk_next;
  logic              len_mismatch;

  router_hold_fifo #(.DEPTH(HOLD_DEPTH), .WIDTH(DATA_W + 1)) u_hold (
    .clock (clock),
    .resetn(resetn),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accumulator seeded from zero on the header, chained from chk_acc_q on payload bytes.
  assign chk_next = DATA_W'(chk_update(PARITY_MODE, DATA_W, CHK_MAX_W'(CRC_POLY),
                                       bus.detect_add ? '0 : CHK_MAX_W'(chk_acc_q),
                                       CHK_MAX_W'(bus.data_in)));
  assign len_mismatch = (byte_cnt_q != DATA_W'(hdr_q[DATA_W-1:ADDR_W]));

  always_comb begin
    hdr_d           = hdr_q;
    chk_acc_d       = chk_acc_q;
    byte_cnt_d      = byte_cnt_q;
    dout_d          = dout_q;
    dout_valid_d    = 1'b0;
    err_d           = err_q;
    len_err_d       = len_err_q;
    hold_ovf_d      = hold_ovf_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    fifo_clr        = 1'b0;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;
    fifo_wdata      = {1'b0, bus.data_in};

    if (bus.lfd_state) begin
      dout_d       = hdr_q;
      dout_valid_d = 1'b1;
    end

    if (bus.detect_add) begin
      if (bus.pkt_valid) begin
        hdr_d         = bus.data_in;
        chk_acc_d     = chk_next;
        byte_cnt_d    = '0;
        err_d         = 1'b0;
        len_err_d     = 1'b0;
        parity_done_d = 1'b0;
        hold_ovf_d    = 1'b0;
        fifo_clr      = 1'b1;
      end
    end else if (bus.ld_state) begin
      if (bus.pkt_valid) begin
        chk_acc_d = chk_next;
        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + DATA_W'(1);
      end else begin
        low_pkt_valid_d = 1'b1;
      end
      // Bypass straight to the FIFO only when nothing is queued, so byte order is kept.
      if (!bus.fifo_full && fifo_empty) begin
        dout_d       = bus.data_in;
        dout_valid_d = 1'b1;
        if (!bus.pkt_valid) begin
          parity_done_d = 1'b1;
          err_d         = (bus.data_in != chk_acc_q);
          len_err_d     = len_mismatch;
        end
      end else begin
        fifo_push  = 1'b1;
        fifo_wdata = {!bus.pkt_valid, bus.data_in};
        if (fifo_full) hold_ovf_d = 1'b1;
      end
    end else if (bus.laf_state && !bus.fifo_full && !fifo_empty) begin
      fifo_pop     = 1'b1;
      dout_d       = fifo_rdata[DATA_W-1:0];
      dout_valid_d = 1'b1;
      if (fifo_rdata[DATA_W]) begin
        parity_done_d = 1'b1;
        err_d         = (fifo_rdata[DATA_W-1:0] != chk_acc_q);
        len_err_d     = len_mismatch;
      end
    end

    if (bus.rst_int_reg) low_pkt_valid_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q           <= '0;
      chk_acc_q       <= '0;
      byte_cnt_q      <= '0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      err_q           <= 1'b0;
      len_err_q       <= 1'b0;
      hold_ovf_q      <= 1'b0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      chk_acc_q       <= chk_acc_d;
      byte_cnt_q      <= byte_cnt_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
      err_q           <= err_d;
      len_err_q       <= len_err_d;
      hold_ovf_q      <= hold_ovf_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.err           = err_q;
  assign bus.len_err       = len_err_q;
  assign bus.hold_ovf      = hold_ovf_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.hold_count    = fifo_count;

endmodule
